// File: rtl/tpu_instr_frontend.sv
// tpu_instr_frontend: instruction front end for the TPU top level.
// Builds 80-bit instructions from three host-written slices in a staging
// register, queues them in a FIFO, and issues the FIFO head to tpu_core
// with a busy/enable handshake.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   enable, flush         global issue enable, synchronous clear
//   lower/middle/upper_instr_word, instr_write_enable
//                         slice data [31:0] / [63:32] / [79:64] and strobes
//   instr_port            FIFO head (show-ahead), 0 when empty
//   instr_enable          issue strobe to core (combinational), pops head
//   busy, synchronize     core busy, core completion pulse
//   fifo_empty, fifo_full, almost_full, fifo_level
//                         FIFO status
//   overflow              sticky: a slice write was dropped
//   runtime_count, issue_count
//                         performance counters
//
// Configuration macro: TPU_FRONTEND_PERF_EN builds the runtime and issue
// counters; without it both counters read 0.
module tpu_instr_frontend #(
  parameter int unsigned FIFO_DEPTH        = 32,
  parameter int unsigned ALMOST_FULL_LEVEL = 28
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          flush,
  input  logic [31:0]                   lower_instr_word,
  input  logic [31:0]                   middle_instr_word,
  input  logic [15:0]                   upper_instr_word,
  input  logic [2:0]                    instr_write_enable,
  output logic [79:0]                   instr_port,
  output logic                          instr_enable,
  input  logic                          busy,
  input  logic                          synchronize,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [31:0]                   runtime_count,
  output logic [31:0]                   issue_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned IW = 80;
  localparam logic [2:0] MASK_FULL = 3'b111;

  logic [IW-1:0] stage_q;
  logic [2:0]    mask_q;
  logic [IW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [LW-1:0] level_q;
  logic          overflow_q;

  logic stage_full;
  logic push;
  logic pop;
  logic drop;

  // Handshake and status decode
  always_comb begin
    stage_full   = (mask_q == MASK_FULL);
    fifo_empty   = (level_q == '0);
    fifo_full    = (level_q == LW'(FIFO_DEPTH));
    almost_full  = (level_q >= LW'(ALMOST_FULL_LEVEL));
    pop          = enable & ~busy & ~fifo_empty & ~flush;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    push         = ~flush & stage_full & (~fifo_full | pop);
    drop         = ~flush & stage_full & ~push & (|instr_write_enable);
    instr_enable = pop;
    fifo_level   = level_q;
    overflow     = overflow_q;
    instr_port   = fifo_empty ? '0 : mem[rd_ptr_q];
  end

  // Staging register: a push clears the mask so same-cycle strobes start the next instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q    <= '0;
      mask_q     <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      mask_q     <= '0;
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else begin
      mask_q <= (push ? 3'b000 : mask_q) | instr_write_enable;
      if (instr_write_enable[0]) stage_q[31:0]  <= lower_instr_word;
      if (instr_write_enable[1]) stage_q[63:32] <= middle_instr_word;
      if (instr_write_enable[2]) stage_q[79:64] <= upper_instr_word;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= stage_q;
  end

  // FIFO pointers and level; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

`ifdef TPU_FRONTEND_PERF_EN
  logic        running_q;
  logic [31:0] runtime_q;
  logic [31:0] issue_q;

  // Runtime: starts at 1 on first issue, counts every cycle, final tick on synchronize
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_q <= 1'b0;
      runtime_q <= '0;
      issue_q   <= '0;
    end else if (flush) begin
      running_q <= 1'b0;
      issue_q   <= '0;
    end else begin
      if (pop) issue_q <= issue_q + 32'd1;
      if (running_q) begin
        if (runtime_q != '1) runtime_q <= runtime_q + 32'd1;
        if (synchronize) running_q <= 1'b0;
      end else if (pop) begin
        runtime_q <= 32'd1;
        running_q <= 1'b1;
      end
    end
  end

  assign runtime_count = runtime_q;
  assign issue_count   = issue_q;
`else
  logic unused_sync;
  assign unused_sync   = synchronize;
  assign runtime_count = '0;
  assign issue_count   = '0;
`endif

endmodule

// File: tb/tb_tpu_instr_frontend.sv
// Testbench for tpu_instr_frontend: scenario tasks plus a randomized run,
// all checked against a queue-based behavioural model of the front end.
module tb_tpu_instr_frontend;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AF    = 28;
  localparam int unsigned LW    = 6;

  logic          clk = 1'b0;
  logic          rst, enable, flush, busy, sync;
  logic [31:0]   lower, middle;
  logic [15:0]   upper;
  logic [2:0]    we;
  logic [79:0]   instr_port;
  logic          instr_enable, fifo_empty, fifo_full, almost_full, overflow;
  logic [LW-1:0] fifo_level;
  logic [31:0]   runtime_count, issue_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tpu_instr_frontend #(.FIFO_DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .lower_instr_word(lower), .middle_instr_word(middle), .upper_instr_word(upper),
    .instr_write_enable(we), .instr_port(instr_port), .instr_enable(instr_enable),
    .busy(busy), .synchronize(sync), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_full(almost_full), .fifo_level(fifo_level), .overflow(overflow),
    .runtime_count(runtime_count), .issue_count(issue_count)
  );

  // Behavioural model: slices with "have" flags, a queue for the FIFO
  logic [79:0] m_q[$];
  logic [31:0] m_lo, m_mid;
  logic [15:0] m_up;
  bit          m_have[3];
  bit          m_ovf, m_run;
  logic [31:0] m_issues, m_rt;

  function automatic bit exp_en();
    return enable && !busy && (m_q.size() != 0) && !flush;
  endfunction

  function automatic logic [79:0] exp_port();
    if (m_q.size() != 0) return m_q[0];
    return '0;
  endfunction

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef TPU_FRONTEND_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_have = '{0, 0, 0};
    m_ovf = 0; m_run = 0; m_issues = 0; m_rt = 0;
    m_lo = 0; m_mid = 0; m_up = 0;
  endtask

  task automatic model_step();
    bit pop, complete, can_push;
    pop = exp_en();
    if (flush) begin
      m_q.delete();
      m_have = '{0, 0, 0};
      m_ovf = 0; m_issues = 0; m_run = 0;
    end else begin
      complete = m_have[0] && m_have[1] && m_have[2];
      can_push = complete && (m_q.size() < DEPTH || pop);
      if (m_run) begin
        if (m_rt != 32'hFFFF_FFFF) m_rt = m_rt + 1;
        if (sync) m_run = 0;
      end else if (pop) begin
        m_rt = 1; m_run = 1;
      end
      if (pop) begin
        void'(m_q.pop_front());
        m_issues = m_issues + 1;
      end
      if (can_push) begin
        m_q.push_back({m_up, m_mid, m_lo});
        m_have = '{0, 0, 0};
      end
      if (we != 0) begin
        if (complete && !can_push) m_ovf = 1;
        else begin
          if (we[0]) begin m_lo  = lower;  m_have[0] = 1; end
          if (we[1]) begin m_mid = middle; m_have[1] = 1; end
          if (we[2]) begin m_up  = upper;  m_have[2] = 1; end
        end
      end
    end
  endtask

  // One clock: model consumes this cycle's inputs, returns at posedge+1
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] w, input logic [31:0] lo, input logic [31:0] mid,
                     input logic [15:0] up);
    we = w; lower = lo; middle = mid; upper = up;
  endtask

  task automatic idle();
    we = 0; flush = 0; sync = 0;
  endtask

  task automatic do_flush();
    flush = 1; we = 0;
    tick();
    flush = 0;
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; busy = 0; idle();
    lower = 0; middle = 0; upper = 0;
    model_reset();
    #3;
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
    checks++; if (instr_enable !== 1'b0) begin errors++; $display("FAIL reset_ien got %b want 0", instr_enable); end
    checks++; if (instr_port !== 80'h0) begin errors++; $display("FAIL reset_port got %h want 0", instr_port); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if ({fifo_full, almost_full, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {fifo_full, almost_full, overflow}); end
    checks++; if ({runtime_count, issue_count} !== 64'h0) begin errors++; $display("FAIL reset_counters got %h want 0", {runtime_count, issue_count}); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int pulses = 0;
    enable = 1; busy = 0;
    put(3'b111, 32'h1111_1111, 32'h2222_2222, 16'h3333);
    tick();
    idle();
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty_n1 got %b want 1", fifo_empty); end
    tick();
    checks++; if (instr_port !== 80'h3333_22222222_11111111) begin errors++; $display("FAIL single_port got %h want 3333_22222222_11111111", instr_port); end
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL single_empty_n2 got %b want 0", fifo_empty); end
    for (int i = 0; i < 4; i++) begin
      if (instr_enable) pulses++;
      tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL single_level got %0d want 0", fifo_level); end
    checks++; if (issue_count !== perf(32'd1)) begin errors++; $display("FAIL single_issue got %0d want %0d", issue_count, perf(32'd1)); end
  endtask

  task automatic test_out_of_order();
    logic [31:0] a, b, m;
    logic [15:0] u;
    a = $urandom; b = $urandom; m = $urandom; u = 16'($urandom);
    busy = 1; enable = 1;
    put(3'b100, 0, 0, u); tick();
    put(3'b001, a, 0, 0); tick();
    put(3'b001, b, 0, 0); tick();
    put(3'b010, 0, m, 0); tick();
    idle();
    repeat (3) tick();
    checks++; if (fifo_level !== LW'(1)) begin errors++; $display("FAIL ooo_level got %0d want 1", fifo_level); end
    checks++; if (instr_port !== {u, m, b}) begin errors++; $display("FAIL ooo_port got %h want %h", instr_port, {u, m, b}); end
    busy = 0;
    tick();
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL ooo_drain got %b want 1", fifo_empty); end
  endtask

  task automatic test_fill();
    logic [79:0] exp_order[$];
    logic [79:0] v;
    bit af_seen = 0;
    do_flush();
    busy = 1; enable = 1;
    for (int i = 0; i < 33; i++) begin
      v = {16'($urandom), 32'($urandom), 32'($urandom)};
      put(3'b111, v[31:0], v[63:32], v[79:64]);
      exp_order.push_back(v);
      tick();
      checks++; if (fifo_level !== LW'(m_q.size())) begin errors++; $display("FAIL fill_level got %0d want %0d", fifo_level, m_q.size()); end
      checks++; if (fifo_full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL fill_full got %b at level %0d", fifo_full, m_q.size()); end
      if (almost_full && !af_seen) begin
        af_seen = 1;
        checks++; if (fifo_level !== LW'(AF)) begin errors++; $display("FAIL fill_af_rise got %0d want %0d", fifo_level, AF); end
      end
    end
    checks++; if (!af_seen) begin errors++; $display("FAIL fill_af_seen got 0 want 1"); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b want 0", overflow); end
    put(3'b111, $urandom, $urandom, 16'($urandom));
    tick();
    idle();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b want 1", overflow); end
    checks++; if (fifo_level !== LW'(DEPTH)) begin errors++; $display("FAIL fill_ovf_level got %0d want %0d", fifo_level, DEPTH); end
    busy = 0;
    #1;
    for (int c = 0; c < 100 && exp_order.size() > 0; c++) begin
      if (instr_enable) begin
        v = exp_order.pop_front();
        checks++; if (instr_port !== v) begin errors++; $display("FAIL fill_order got %h want %h", instr_port, v); end
      end
      tick();
    end
    checks++; if (exp_order.size() != 0) begin errors++; $display("FAIL fill_drain_left got %0d want 0", exp_order.size()); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL fill_drain_empty got %b want 1", fifo_empty); end
  endtask

  task automatic test_push_pop_full();
    logic [79:0] exp_order[$];
    logic [79:0] v;
    do_flush();
    busy = 1; enable = 1;
    for (int i = 0; i < 33; i++) begin
      v = {16'($urandom), 32'($urandom), 32'($urandom)};
      put(3'b111, v[31:0], v[63:32], v[79:64]);
      exp_order.push_back(v);
      tick();
    end
    busy = 0;
    for (int c = 0; c < 200 && exp_order.size() > 0; c++) begin
      if (c < 20) begin
        v = {16'($urandom), 32'($urandom), 32'($urandom)};
        put(3'b111, v[31:0], v[63:32], v[79:64]);
        exp_order.push_back(v);
      end else we = 0;
      #1;
      if (instr_enable) begin
        v = exp_order.pop_front();
        checks++; if (instr_port !== v) begin errors++; $display("FAIL ppf_order got %h want %h", instr_port, v); end
      end
      tick();
      if (c < 20) begin
        checks++; if (fifo_level !== LW'(DEPTH)) begin errors++; $display("FAIL ppf_level got %0d want %0d", fifo_level, DEPTH); end
      end
    end
    checks++; if (exp_order.size() != 0) begin errors++; $display("FAIL ppf_left got %0d want 0", exp_order.size()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ppf_ovf got %b want 0", overflow); end
  endtask

  task automatic test_runtime();
    do_flush();
    busy = 1; enable = 1;
    put(3'b111, $urandom, $urandom, 16'($urandom)); tick();
    put(3'b111, $urandom, $urandom, 16'($urandom)); tick();
    idle();
    repeat (5) tick();
    busy = 0;
    #1;
    checks++; if (instr_enable !== 1'b1) begin errors++; $display("FAIL rt_issue got %b want 1", instr_enable); end
    tick();
    busy = 1;
    repeat (14) tick();
    sync = 1; tick(); sync = 0;
    checks++; if (runtime_count !== perf(32'd16)) begin errors++; $display("FAIL rt_final got %0d want %0d", runtime_count, perf(32'd16)); end
    repeat (3) tick();
    checks++; if (runtime_count !== perf(32'd16)) begin errors++; $display("FAIL rt_hold got %0d want %0d", runtime_count, perf(32'd16)); end
    sync = 1; tick(); sync = 0;
    checks++; if (runtime_count !== perf(32'd16)) begin errors++; $display("FAIL rt_spurious got %0d want %0d", runtime_count, perf(32'd16)); end
    busy = 0; tick(); busy = 1;
    checks++; if (runtime_count !== perf(32'd1)) begin errors++; $display("FAIL rt_restart got %0d want %0d", runtime_count, perf(32'd1)); end
    checks++; if (issue_count !== perf(32'd2)) begin errors++; $display("FAIL rt_issues got %0d want %0d", issue_count, perf(32'd2)); end
    repeat (4) tick();
    checks++; if (runtime_count !== perf(m_rt) || m_rt != 32'd5) begin errors++; $display("FAIL rt_count got %0d want %0d", runtime_count, perf(32'd5)); end
    sync = 1; tick(); sync = 0;
  endtask

  task automatic test_flush();
    logic [31:0] lo, mid;
    logic [15:0] up;
    do_flush();
    busy = 1; enable = 1;
    for (int i = 0; i < 34; i++) begin
      put(3'b111, $urandom, $urandom, 16'($urandom));
      tick();
    end
    idle();
    busy = 0;
    for (int c = 0; c < 100 && m_q.size() > 5; c++) tick();
    busy = 1;
    put(3'b001, $urandom, 0, 0); tick(); idle();
    checks++; if (fifo_level !== LW'(5)) begin errors++; $display("FAIL flush_pre_level got %0d want 5", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf got %b want 1", overflow); end
    flush = 1; busy = 0;
    #1;
    checks++; if (instr_enable !== 1'b0) begin errors++; $display("FAIL flush_ien got %b want 0", instr_enable); end
    tick();
    flush = 0; busy = 1;
    checks++; if (fifo_level !== '0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_level got %0d/%b want 0/1", fifo_level, fifo_empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got %b want 0", overflow); end
    checks++; if (issue_count !== 32'd0) begin errors++; $display("FAIL flush_issue got %0d want 0", issue_count); end
    mid = $urandom; up = 16'($urandom); lo = $urandom;
    put(3'b110, 0, mid, up); tick(); idle();
    repeat (2) tick();
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL flush_mask got %0d want 0", fifo_level); end
    put(3'b001, lo, 0, 0); tick(); idle();
    repeat (2) tick();
    checks++; if (fifo_level !== LW'(1)) begin errors++; $display("FAIL flush_refill got %0d want 1", fifo_level); end
    checks++; if (instr_port !== {up, mid, lo}) begin errors++; $display("FAIL flush_port got %h want %h", instr_port, {up, mid, lo}); end
  endtask

  task automatic test_random();
    do_flush();
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 7) != 0);
      busy   = ($urandom_range(0, 1) == 1);
      we     = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom);
      lower  = $urandom; middle = $urandom; upper = 16'($urandom);
      flush  = ($urandom_range(0, 63) == 0);
      sync   = ($urandom_range(0, 15) == 0);
      #1;
      checks++; if (instr_enable !== exp_en()) begin errors++; $display("FAIL rnd_ien c%0d got %b want %b", c, instr_enable, exp_en()); end
      checks++; if (instr_port !== exp_port()) begin errors++; $display("FAIL rnd_port c%0d got %h want %h", c, instr_port, exp_port()); end
      checks++; if (fifo_level !== LW'(m_q.size())) begin errors++; $display("FAIL rnd_level c%0d got %0d want %0d", c, fifo_level, m_q.size()); end
      checks++; if ({fifo_empty, fifo_full, almost_full} !== {m_q.size() == 0, m_q.size() == DEPTH, m_q.size() >= AF}) begin
        errors++; $display("FAIL rnd_flags c%0d got %b level %0d", c, {fifo_empty, fifo_full, almost_full}, m_q.size()); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d got %b want %b", c, overflow, m_ovf); end
      checks++; if (runtime_count !== perf(m_rt)) begin errors++; $display("FAIL rnd_rt c%0d got %0d want %0d", c, runtime_count, perf(m_rt)); end
      checks++; if (issue_count !== perf(m_issues)) begin errors++; $display("FAIL rnd_issue c%0d got %0d want %0d", c, issue_count, perf(m_issues)); end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_flush();
    enable = 1; busy = 1;
    for (int i = 0; i < 6; i++) begin
      put(3'b111, $urandom, $urandom, 16'($urandom));
      tick();
    end
    put(3'b011, $urandom, $urandom, 0);
    busy = 0;
    repeat (2) tick();
    #2;
    rst = 1;
    #1;
    checks++; if (fifo_empty !== 1'b1 || fifo_level !== '0) begin errors++; $display("FAIL arst_fifo got %b/%0d want 1/0", fifo_empty, fifo_level); end
    checks++; if (instr_port !== 80'h0 || instr_enable !== 1'b0) begin errors++; $display("FAIL arst_port got %h/%b want 0/0", instr_port, instr_enable); end
    checks++; if ({fifo_full, almost_full, overflow} !== 3'b000) begin errors++; $display("FAIL arst_flags got %b want 000", {fifo_full, almost_full, overflow}); end
    checks++; if ({runtime_count, issue_count} !== 64'h0) begin errors++; $display("FAIL arst_counters got %h want 0", {runtime_count, issue_count}); end
    model_reset();
    idle();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    busy = 1;
    put(3'b111, $urandom, $urandom, 16'($urandom)); tick(); idle();
    repeat (2) tick();
    checks++; if (fifo_level !== LW'(1)) begin errors++; $display("FAIL arst_recover got %0d want 1", fifo_level); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_out_of_order();
    test_fill();
    test_push_pop_full();
    test_runtime();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
